// File: rtl/line_raster.sv
// Bresenham line rasterizer: takes one line command, emits one in-bounds
// frame-buffer write beat (linear address + colour) per visited point.
//   state   | meaning
//   S_IDLE  | waiting for a command
//   S_SETUP | compute deltas, error term and step directions
//   S_DRAW  | visit one point per free output slot
//   S_FLUSH | wait for the final beat to drain, then pulse O_DONE
module line_raster #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 400,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 18,
  parameter int COLOR_W = 16
) (
  input  logic               I_CLK,
  input  logic               I_RST,
  input  logic               I_CMD_VALID,
  output logic               O_CMD_READY,
  input  logic [COORD_W-1:0] I_X0,
  input  logic [COORD_W-1:0] I_Y0,
  input  logic [COORD_W-1:0] I_X1,
  input  logic [COORD_W-1:0] I_Y1,
  input  logic [COLOR_W-1:0] I_COLOR,
  output logic               O_PIX_VALID,
  input  logic               I_PIX_READY,
  output logic [ADDR_W-1:0]  O_PIX_ADDR,
  output logic [COLOR_W-1:0] O_PIX_DATA,
  output logic [COORD_W-1:0] O_PIX_X,
  output logic [COORD_W-1:0] O_PIX_Y,
  output logic               O_BUSY,
  output logic               O_DONE
);

  localparam int EW = COORD_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_FLUSH} state_t;
  state_t state_q, state_d;

  logic [COORD_W-1:0]    x0_q, y0_q, x1_q, y1_q, x_q, y_q;
  logic [COLOR_W-1:0]    color_q;
  logic signed [EW-1:0]  dx_q, dy_q, err_q;
  logic                  sx_q, sy_q;
  logic                  pix_valid_q, done_q;
  logic [ADDR_W-1:0]     pix_addr_q;
  logic [COLOR_W-1:0]    pix_data_q;
  logic [COORD_W-1:0]    pix_x_q, pix_y_q;

  logic                  slot_free, at_end, in_bounds, step_x, step_y;
  logic signed [EW:0]    e2, dx_e, dy_e;
  logic signed [EW-1:0]  err_step;
  logic [COORD_W-1:0]    adx, ady;
  logic [ADDR_W-1:0]     addr_c;

  assign slot_free = !pix_valid_q || I_PIX_READY;
  assign at_end    = (x_q == x1_q) && (y_q == y1_q);
  assign in_bounds = (x_q < COORD_W'(H_RES)) && (y_q < COORD_W'(V_RES));

  // e2 and the deltas share one width so the compares stay signed
  assign e2       = {err_q, 1'b0};
  assign dx_e     = {dx_q[EW-1], dx_q};
  assign dy_e     = {dy_q[EW-1], dy_q};
  assign step_x   = (e2 >= dy_e);
  assign step_y   = (e2 <= dx_e);
  assign err_step = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);

  assign adx    = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
  assign ady    = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
  assign addr_c = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);

  always_ff @(posedge I_CLK) begin
    if (I_RST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (I_CMD_VALID) state_d = S_SETUP;
      S_SETUP: state_d = S_DRAW;
      S_DRAW:  if (slot_free && at_end) state_d = S_FLUSH;
      S_FLUSH: if (slot_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_CMD_READY = (state_q == S_IDLE);
    O_BUSY      = (state_q != S_IDLE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0;
      x_q <= '0; y_q <= '0; color_q <= '0;
      dx_q <= '0; dy_q <= '0; err_q <= '0; sx_q <= 1'b0; sy_q <= 1'b0;
      pix_valid_q <= 1'b0; done_q <= 1'b0;
      pix_addr_q <= '0; pix_data_q <= '0; pix_x_q <= '0; pix_y_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (I_CMD_VALID) begin
            x0_q <= I_X0; y0_q <= I_Y0; x1_q <= I_X1; y1_q <= I_Y1;
            color_q <= I_COLOR;
          end
        end
        S_SETUP: begin
          dx_q  <= EW'(adx);
          dy_q  <= -EW'(ady);
          err_q <= EW'(adx) - EW'(ady);
          sx_q  <= (x0_q < x1_q);
          sy_q  <= (y0_q < y1_q);
          x_q   <= x0_q;
          y_q   <= y0_q;
        end
        S_DRAW: begin
          if (slot_free) begin
            // clipped points are visited but produce no beat
            pix_valid_q <= in_bounds;
            if (in_bounds) begin
              pix_addr_q <= addr_c;
              pix_data_q <= color_q;
              pix_x_q    <= x_q;
              pix_y_q    <= y_q;
            end
            if (!at_end) begin
              err_q <= err_step;
              if (step_x) x_q <= sx_q ? x_q + COORD_W'(1) : x_q - COORD_W'(1);
              if (step_y) y_q <= sy_q ? y_q + COORD_W'(1) : y_q - COORD_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (slot_free) begin
            pix_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_PIX_VALID = pix_valid_q;
  assign O_PIX_ADDR  = pix_addr_q;
  assign O_PIX_DATA  = pix_data_q;
  assign O_PIX_X     = pix_x_q;
  assign O_PIX_Y     = pix_y_q;
  assign O_DONE      = done_q;

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster: directed lines plus random lines with
// random back-pressure, compared against a plain integer Bresenham model.
module tb_line_raster;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        pix_ready = 1'b0;
  logic        cmd_ready, pix_valid, busy, done;
  logic [9:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] color = '0, pix_data;
  logic [17:0] pix_addr;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {int x; int y;} pt_t;
  pt_t exp_q[$];

  always #5 clk = ~clk;

  line_raster dut (
    .I_CLK(clk), .I_RST(rst),
    .I_CMD_VALID(cmd_valid), .O_CMD_READY(cmd_ready),
    .I_X0(x0), .I_Y0(y0), .I_X1(x1), .I_Y1(y1), .I_COLOR(color),
    .O_PIX_VALID(pix_valid), .I_PIX_READY(pix_ready),
    .O_PIX_ADDR(pix_addr), .O_PIX_DATA(pix_data),
    .O_PIX_X(pix_x), .O_PIX_Y(pix_y),
    .O_BUSY(busy), .O_DONE(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the textbook integer Bresenham walk; keep only on-screen points.
  task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    pt_t p;
    exp_q.delete();
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x = ax0; y = ay0;
    forever begin
      if (x < 640 && y < 400) begin
        p.x = x; p.y = y;
        exp_q.push_back(p);
      end
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  function automatic logic next_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 1);
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  // mode: 0 ready always high, 1 ready 1,0,0 pattern, 2 random ready + busy-time junk
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic [15:0] col, input int mode, input int abort_after);
    int cyc, beats, first_beat, pts, adx, ady;
    logic prev_stall, done_seen, first_in;
    logic [17:0] h_addr;
    logic [15:0] h_data;
    logic [9:0]  h_x, h_y;
    pt_t p;
    model(ax0, ay0, ax1, ay1);
    adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    pts = ((adx > ady) ? adx : ady) + 1;
    first_in = (ax0 < 640) && (ay0 < 400);

    cyc = 0;
    @(negedge clk);
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1); color = col;
    cmd_valid = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);

    cyc = 1; beats = 0; first_beat = -1; prev_stall = 1'b0; done_seen = 1'b0;
    h_addr = '0; h_data = '0; h_x = '0; h_y = '0;
    while (cyc < 20000) begin
      if (done) begin
        cmd_valid = 1'b0;
        done_seen = 1'b1;
        break;
      end
      if (abort_after > 0 && beats == abort_after) begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_pix_addr", int'(pix_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_done", int'(done), 0);
        return;
      end
      if (prev_stall) begin
        chk("hold_valid", int'(pix_valid), 1);
        chk("hold_addr", int'(pix_addr), int'(h_addr));
        chk("hold_data", int'(pix_data), int'(h_data));
        chk("hold_xy", int'({pix_x, pix_y}), int'({h_x, h_y}));
      end
      if (pix_valid && first_beat < 0) first_beat = cyc;
      pix_ready = next_ready(mode, cyc);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", int'(pix_addr), -1);
        end else begin
          p = exp_q.pop_front();
          chk("beat_addr", int'(pix_addr), p.y * 640 + p.x);
          chk("beat_data", int'(pix_data), int'(col));
          chk("beat_x", int'(pix_x), p.x);
          chk("beat_y", int'(pix_y), p.y);
        end
        beats++;
      end
      prev_stall = pix_valid && !pix_ready;
      h_addr = pix_addr; h_data = pix_data; h_x = pix_x; h_y = pix_y;
      if (mode == 2 && !cmd_ready) begin
        cmd_valid = 1'($urandom_range(0, 1));
        x0 = 10'($urandom); y0 = 10'($urandom); x1 = 10'($urandom); y1 = 10'($urandom);
        color = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end

    if (!done_seen) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("done_cmd_ready", int'(cmd_ready), 1);
    chk("beats_missing", exp_q.size(), 0);
    if (mode == 0) begin
      chk("done_latency", cyc, pts + 3);
      if (first_in) chk("first_beat_latency", first_beat, 3);
    end
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_pix_valid", int'(pix_valid), 0);
    chk("reset_pix_addr", int'(pix_addr), 0);
    chk("reset_pix_data", int'(pix_data), 0);
    chk("reset_pix_xy", int'({pix_x, pix_y}), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;

    run_line(0, 0, 3, 0, 16'hFFFF, 0, 0);
    run_line(50, 50, 200, 200, 16'h003F, 0, 0);
    run_line(10, 5, 2, 1, 16'h1234, 0, 0);
    run_line(0, 0, 3, 0, 16'hA5A5, 1, 0);
    run_line(638, 399, 641, 399, 16'h0F0F, 0, 0);
    run_line(700, 500, 700, 500, 16'hBEEF, 0, 0);
    run_line(50, 50, 200, 200, 16'h003F, 0, 3);
    run_line(7, 7, 7, 7, 16'h7777, 0, 0);
    run_line(3, 9, 3, 0, 16'h4321, 1, 0);

    for (int i = 0; i < 30; i++) begin
      int ax0, ay0, ax1, ay1;
      ax0 = $urandom_range(0, 1023);
      ay0 = $urandom_range(0, 511);
      ax1 = clamp(ax0 + int'($urandom_range(0, 160)) - 80);
      ay1 = clamp(ay0 + int'($urandom_range(0, 160)) - 80);
      run_line(ax0, ay0, ax1, ay1, 16'($urandom), int'($urandom_range(0, 2)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/line_raster.md
# line_raster

Bresenham line rasterizer that sits directly upstream of the GPU frame-buffer SRAM writer. It accepts one line command at a time: two endpoints plus a 16-bit colour. It emits one in-bounds pixel per cycle as a frame-buffer write beat carrying a linear address (row × 640 + column) and colour data. The SRAM writer consumes those beats in place of its own per-pixel test logic.

## Interface
- H_RES, 640, frame width in pixels; also the address row stride
- V_RES, 400, frame height in pixels
- COORD_W, 10, endpoint coordinate width (unsigned)
- ADDR_W, 18, frame-buffer address width
- COLOR_W, 16, pixel data width ({4'hR,4'hG,4'hB,4'hA} packing)

Ports:
- I_CLK  in  1  clock; all state changes on rising edge
- I_RST  in  1  reset; synchronous, active-high
- I_CMD_VALID  in  1  command present
- O_CMD_READY  out  1  engine can accept a command (high only in IDLE)
- I_X0, I_Y0, I_X1, I_Y1  in  COORD_W each  line endpoints; drawing starts at (X0,Y0)
- I_COLOR  in  COLOR_W  line colour
- O_PIX_VALID  out  1  write beat present
- I_PIX_READY  in  1  downstream accepts the beat
- O_PIX_ADDR  out  ADDR_W  Y*H_RES+X
- O_PIX_DATA  out  COLOR_W  colour
- O_PIX_X, O_PIX_Y  out  COORD_W  pixel coordinate, for debug and seven-segment display
- O_BUSY  out  1  state != IDLE
- O_DONE  out  1  one-cycle pulse at line completion

## Operation
- Reset values: O_CMD_READY=1, O_PIX_VALID=0, O_PIX_ADDR=0, O_PIX_DATA=0, O_PIX_X=0, O_PIX_Y=0, O_BUSY=0, O_DONE=0, state=IDLE.
- States:
  - IDLE: on I_CMD_VALID && O_CMD_READY, latch the endpoints and colour; go to SETUP.
  - SETUP: compute the Bresenham terms below; set x=X0, y=Y0; go to DRAW.
  - DRAW: step the line (rules below).
  - FLUSH: wait for the last beat to be accepted, then pulse O_DONE and return to IDLE.
- SETUP terms:
  - dx=|X1−X0|, dy=−|Y1−Y0|
  - sx=+1 if X0<X1 else −1; sy=+1 if Y0<Y1 else −1
  - err=dx+dy
- Widths: err is signed COORD_W+2 bits. e2=2·err is signed COORD_W+3 bits. No overflow is possible for 10-bit coordinates.
- DRAW advances only when the output slot is free, i.e. !O_PIX_VALID || I_PIX_READY. On an advance:
  - If x<H_RES and y<V_RES, load O_PIX_* with (x, y, y*H_RES+x, colour) and set O_PIX_VALID=1. Otherwise set O_PIX_VALID=0: the pixel is clipped and no beat is issued.
  - If x==X1 and y==Y1, go to FLUSH.
  - Otherwise step: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. When both conditions hold, both updates apply in the same cycle using the pre-update err.
- O_PIX_* hold stable while O_PIX_VALID && !I_PIX_READY.
- Points visited per line: max(dx,|dy|)+1. Beats emitted per line: the in-bounds subset of those points.
- Degenerate line (X0==X1 and Y0==Y1): exactly one point is visited.
- FLUSH exits the first cycle in which O_PIX_VALID==0, or O_PIX_VALID && I_PIX_READY. On exit O_PIX_VALID drops (unless the handshake already cleared it) and O_DONE=1 for one cycle.
- A fully clipped line emits no beats and still pulses O_DONE.
- Commands offered while busy are ignored, not queued. I_CMD_VALID must be held until accepted.
- I_RST asserted mid-line forces the reset values on the next edge. Any pending beat is dropped, with no O_DONE pulse.

## Timing
- Command accepted at edge N. SETUP occupies cycle N+1. First beat is valid after edge N+2 when (X0,Y0) is in bounds.
- Throughput: one visited point per cycle while I_PIX_READY=1.
- Final beat handshake at edge M: O_DONE is high and O_CMD_READY is high during cycle M+1. A new command can be accepted at edge M+1.
- Back-to-back commands: minimum three cycles between a command acceptance and its O_DONE (single point, READY held high).
- The address multiply may be pipelined internally only if the O_PIX_* timing above is unchanged.

## Test plan
- (0,0)→(3,0), colour 0xFFFF, READY=1: beats at addr 0,1,2,3 on consecutive cycles; O_DONE in the cycle after the last beat.
- (50,50)→(200,200), colour 0x003F: 151 beats; first addr 32050, last 128200; each addr = previous + 641.
- (10,5)→(2,1), reverse octant: 9 beats, x decreasing 10→2, y decreasing 5→1; last beat (2,1), addr 642.
- (0,0)→(3,0) with READY toggling 1,0,0,1,…: O_PIX_* stable while stalled; exactly 4 beats, no duplicates or drops.
- (638,399)→(641,399): beats only at addr 255998 and 255999; 4 points visited; O_DONE still pulses. A command of (700,500)→(700,500) gives 0 beats plus an O_DONE pulse.
- I_RST after the 3rd beat of (50,50)→(200,200): next cycle O_PIX_VALID=0, O_BUSY=0, O_CMD_READY=1, no O_DONE. A new single-point command at (7,7) yields one beat at addr 4487.
